ifu: RTL
========

# ifu

Instruction fetch unit for the npc RV32 core. Accepts the fetch address produced by the PC register, issues a single-outstanding read to instruction memory over a valid/ready request/response bus, and presents the returned instruction with its PC to decode. Handles redirect flushes from jal/jalr by discarding in-flight fetches.

## Interface
- `ADDR_W`, 32, address and PC width.
- `DATA_W`, 32, instruction width.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc_i`  in  ADDR_W  fetch address from the PC register.
- `pc_valid_i`  in  1  `pc_i` is valid.
- `pc_ready_o`  out  1  IFU accepts `pc_i` this cycle.
- `flush_i`  in  1  redirect (taken jal/jalr); kills current fetch.
- `mem_req_valid_o`  out  1  memory read request valid.
- `mem_req_addr_o`  out  ADDR_W  request address.
- `mem_req_ready_i`  in  1  memory accepts request.
- `mem_resp_valid_i`  in  1  response data valid.
- `mem_resp_data_i`  in  DATA_W  fetched word.
- `mem_resp_ready_o`  out  1  IFU accepts response.
- `inst_valid_o`  out  1  instruction to decode valid.
- `inst_o`  out  DATA_W  instruction.
- `inst_pc_o`  out  ADDR_W  PC of `inst_o`.
- `inst_ready_i`  in  1  decode consumes instruction.
- `fault_o`  out  1  misaligned-fetch flag, qualified by `inst_valid_o` (present only with `IFU_ALIGN_CHECK_EN`).

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD. Reset to IDLE.
- IDLE: `pc_ready_o = !flush_i`. On `pc_valid_i && pc_ready_o`: latch `pc_i` into `mem_req_addr_o` and `inst_pc_o`, go to REQ.
- REQ: `mem_req_valid_o=1`; address stable. Valid is never withdrawn before `mem_req_ready_i`. On handshake go to WAIT.
- WAIT: `mem_resp_ready_o=1`. On `mem_resp_valid_i`: latch data into `inst_o`, go to HOLD; if drop flag set, discard data, clear drop, go to IDLE.
- HOLD: `inst_valid_o=1`; `inst_o`/`inst_pc_o` stable until `inst_ready_i`, then go to IDLE.
- Flush: IDLE — no effect besides blocking acceptance. REQ — set 1-bit drop flag; request still completes. WAIT — set drop; a response arriving in the same cycle is discarded and FSM goes to IDLE. HOLD — `inst_valid_o` deasserts next cycle, go to IDLE, no consume needed.
- Only one memory transaction outstanding; drop flag is sufficient.
- Responses outside WAIT are not accepted (`mem_resp_ready_o=0`).

## Timing
- Reset values: all valid/ready outputs 0 (except `pc_ready_o`, which is 1 in IDLE once `rst` deasserts and `flush_i=0`); `mem_req_addr_o`, `inst_o`, `inst_pc_o` = 0; drop = 0; `fault_o` = 0.
- Best case with zero-wait memory: pc accepted cycle 0, request valid cycle 1, response accepted cycle 2, `inst_valid_o` cycle 3, next pc accepted cycle 4 if consumed cycle 3.
- `pc_ready_o` is the only output combinational on an input (`flush_i`); all others are registered/state-decoded.
- `rst` mid-transaction returns to IDLE immediately; the memory side must tolerate an abandoned request.

## Configuration
- `IFU_ALIGN_CHECK_EN` defined: on acceptance, if `pc_i[1:0] != 0`, no memory request is issued; FSM goes directly to HOLD with `inst_o=32'h0000_0013` (nop), `fault_o=1`, `inst_pc_o=pc_i`. `fault_o` is 0 for aligned fetches.
- Undefined: no `fault_o` port; `pc_i` forwarded unchanged to `mem_req_addr_o`.

## Structure
- `ifu_pkg`: FSM state enum, `NOP_INST = 32'h0000_0013`, `RESET_PC = 32'h8000_0000` (shared with the PC register).
- Single module; no sub-module needed.

## Test plan
- Zero-wait memory, `pc_i=32'h8000_0000`, mem returns `32'h00000297` -> `inst_valid_o` at cycle 3 with `inst_o=32'h00000297`, `inst_pc_o=32'h80000000`.
- `mem_req_ready_i` held low 4 cycles -> `mem_req_valid_o` and `mem_req_addr_o` stable throughout; instruction delivered 4 cycles later.
- `flush_i` pulse in WAIT, response `32'hdeadbeef` 2 cycles later -> response accepted and discarded, `inst_valid_o` never asserts, FSM IDLE.
- `flush_i` in HOLD with `inst_ready_i=0` -> `inst_valid_o` drops next cycle, new pc `32'h80000100` accepted the cycle after.
- `rst` asserted in REQ -> all outputs return to reset values asynchronously; after release, fetch of `32'h80000000` completes normally.
- With `IFU_ALIGN_CHECK_EN`, `pc_i=32'h80000002` -> no `mem_req_valid_o`, `inst_valid_o=1`, `fault_o=1`, `inst_o=32'h00000013` at cycle 1.

Source files
------------

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the npc instruction fetch unit
package ifu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } ifu_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu.sv
// rtl/ifu.sv - single-outstanding instruction fetch unit with redirect flush
// Optional misaligned-fetch fault: IFU_ALIGN_CHECK_EN
module ifu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  output logic              pc_ready_o,
  input  logic              flush_i,
  output logic              mem_req_valid_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  input  logic              mem_req_ready_i,
  input  logic              mem_resp_valid_i,
  input  logic [DATA_W-1:0] mem_resp_data_i,
  output logic              mem_resp_ready_o,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i
`ifdef IFU_ALIGN_CHECK_EN
  ,
  output logic              fault_o
`endif
);

  import ifu_pkg::*;

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] inst_q;
  logic              drop_q, drop_d;
  logic              load_pc;
  logic              load_inst;

`ifdef IFU_ALIGN_CHECK_EN
  logic              misaligned;
  logic              load_nop;
  logic              fault_q;

  assign misaligned = (pc_i[1:0] != 2'b00);
`endif

  // drop remembers that the single in-flight fetch was killed by a redirect
  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    pc_ready_o = 1'b0;
    load_pc    = 1'b0;
    load_inst  = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
    load_nop   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        pc_ready_o = !flush_i;
        if (pc_valid_i && !flush_i) begin
          load_pc = 1'b1;
`ifdef IFU_ALIGN_CHECK_EN
          if (misaligned) begin
            load_nop = 1'b1;
            state_d  = S_HOLD;
          end else begin
            state_d  = S_REQ;
          end
`else
          state_d = S_REQ;
`endif
        end
      end
      S_REQ: begin
        if (flush_i) drop_d = 1'b1;
        if (mem_req_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid_i) begin
          if (drop_q || flush_i) begin
            drop_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            load_inst = 1'b1;
            state_d   = S_HOLD;
          end
        end else if (flush_i) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (flush_i || inst_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= '0;
      inst_q <= '0;
    end else begin
      if (load_pc) pc_q <= pc_i;
      if (load_inst) inst_q <= mem_resp_data_i;
`ifdef IFU_ALIGN_CHECK_EN
      if (load_nop) inst_q <= DATA_W'(NOP_INST);
`endif
    end
  end

`ifdef IFU_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (load_pc) begin
      fault_q <= misaligned;
    end
  end

  assign fault_o = fault_q;
`endif

  assign mem_req_valid_o  = (state_q == S_REQ);
  assign mem_resp_ready_o = (state_q == S_WAIT);
  assign inst_valid_o     = (state_q == S_HOLD);
  assign mem_req_addr_o   = pc_q;
  assign inst_pc_o        = pc_q;
  assign inst_o           = inst_q;

endmodule
